pulse_stretcher: RTL and testbench

- Output-side counterpart to the button input path. The debouncer turns a slow human press into a one-cycle `clk` pulse; this block turns one-cycle `clk` event pulses into human-visible LED blinks.
- Every accepted event produces exactly one blink: an ON window followed by an OFF gap.
- Events that arrive while a blink is in progress are queued in a saturating pending counter.
- Sits between stopwatch control logic (pause/reset/adjust events) and board LEDs.

---
 rtl/pulse_stretcher_pkg.sv | 20 ++
 rtl/cycle_timer.sv | 38 +++
 rtl/pulse_stretcher.sv | 130 +++++++++++++
 tb/tb_pulse_stretcher.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and defaults for the pulse stretcher and related stopwatch timing blocks.
// Default cycle counts assume the same 100 MHz board clock as the debouncer.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ         = 100_000_000;
  localparam int unsigned DEF_ON_CYCLES  = CLK_HZ / 20;
  localparam int unsigned DEF_GAP_CYCLES = CLK_HZ / 20;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that parks at zero; clr has priority over load.
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Turns one-cycle event strobes into visible LED blinks (ON window then OFF gap),
// queueing events that arrive mid-blink in a saturating pending counter.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              dropped
);

  localparam int unsigned       TW       = $clog2(max_u(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]     T_MAX    = (ON_CYCLES >= GAP_CYCLES) ? ON_LOAD : GAP_LOAD;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              dropped_q, dropped_d;

  logic              t_clr, t_load, t_zero;
  logic [TW-1:0]     t_load_val, t_value;
  logic              inc, dec;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (t_load_val),
    .value    (t_value),
    .zero     (t_zero)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    dropped_d  = 1'b0;
    t_clr      = 1'b0;
    t_load     = 1'b0;
    t_load_val = '0;
    inc        = 1'b0;
    dec        = 1'b0;

    if (clear) begin
      state_d   = ST_IDLE;
      pending_d = '0;
      t_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_in) begin
            state_d    = ST_ON;
            t_load     = 1'b1;
            t_load_val = ON_LOAD;
          end
        end
        ST_ON: begin
          inc = pulse_in;
          if (t_zero) begin
            state_d    = ST_GAP;
            t_load     = 1'b1;
            t_load_val = GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (!t_zero) begin
            inc = pulse_in;
          end else if (pending_q != '0) begin
            // Queued events go first; a fresh strobe this cycle joins the queue.
            state_d    = ST_ON;
            t_load     = 1'b1;
            t_load_val = ON_LOAD;
            dec        = 1'b1;
            inc        = pulse_in;
          end else if (pulse_in) begin
            state_d    = ST_ON;
            t_load     = 1'b1;
            t_load_val = ON_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          t_clr   = 1'b1;
        end
      endcase

      if (inc && !dec) begin
        if (pending_q == PEND_MAX) begin
          dropped_d = 1'b1;
        end else begin
          pending_d = pending_q + PEND_W'(1);
        end
      end else if (dec && !inc) begin
        pending_d = pending_q - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign led     = (state_q == ST_ON);
  assign busy    = (state_q != ST_IDLE);
  assign pending = pending_q;
  assign dropped = dropped_q;

  timer_in_range: assert property (@(posedge clk) disable iff (!rst_n) t_value <= T_MAX);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON=3, GAP=2, PEND_W=2; edges counted from 1 after reset release.
module tb_pulse_stretcher;

  localparam int unsigned PW = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          pulse_in = 1'b0;
  logic          clear    = 1'b0;
  logic          led;
  logic          busy;
  logic          dropped;
  logic [PW-1:0] pending;

  int total = 0;
  int bad   = 0;

  pulse_stretcher #(
    .ON_CYCLES  (3),
    .GAP_CYCLES (2),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .clear    (clear),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string t, input int e, input int l, input int b, input int p, input int d);
    chk($sformatf("%s e%0d led", t, e), int'(led), l);
    chk($sformatf("%s e%0d busy", t, e), int'(busy), b);
    chk($sformatf("%s e%0d pending", t, e), int'(pending), p);
    chk($sformatf("%s e%0d dropped", t, e), int'(dropped), d);
  endtask

  task automatic step(input logic p, input logic c);
    pulse_in = p;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rng(input int e, input int a, input int b);
    return (e >= a && e <= b) ? 1 : 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int p_exp;

    // 1: reset held with toggling input, then idle after release
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse_in = (i % 2 == 0);
      @(posedge clk);
      #1;
      chk_out("rst_hold", i, 0, 0, 0, 0);
    end
    pulse_in = 1'b0;
    rst_n    = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step(1'b0, 1'b0);
      chk_out("idle", e, 0, 0, 0, 0);
    end

    // 2: single pulse at edge 10
    reset_dut();
    for (int e = 1; e <= 18; e++) begin
      step(e == 10, 1'b0);
      chk_out("single", e, rng(e, 10, 12), rng(e, 10, 14), 0, 0);
    end

    // 3: pulses at 10,11,12
    reset_dut();
    for (int e = 1; e <= 28; e++) begin
      step(rng(e, 10, 12) == 1, 1'b0);
      if (e == 11)                p_exp = 1;
      else if (rng(e, 12, 14) == 1) p_exp = 2;
      else if (rng(e, 15, 19) == 1) p_exp = 1;
      else                        p_exp = 0;
      chk_out("three", e,
              rng(e, 10, 12) | rng(e, 15, 17) | rng(e, 20, 22),
              rng(e, 10, 24), p_exp, 0);
    end

    // 4: five pulses at 10..14, saturation at 3 and one drop
    reset_dut();
    for (int e = 1; e <= 33; e++) begin
      step(rng(e, 10, 14) == 1, 1'b0);
      if (e == 11)                p_exp = 1;
      else if (e == 12)           p_exp = 2;
      else if (rng(e, 13, 14) == 1) p_exp = 3;
      else if (rng(e, 15, 19) == 1) p_exp = 2;
      else if (rng(e, 20, 24) == 1) p_exp = 1;
      else                        p_exp = 0;
      chk_out("sat", e,
              rng(e, 10, 12) | rng(e, 15, 17) | rng(e, 20, 22) | rng(e, 25, 27),
              rng(e, 10, 29), p_exp, (e == 14) ? 1 : 0);
    end

    // 5: second pulse in the final GAP cycle (sampled at edge 15) chains directly
    reset_dut();
    for (int e = 1; e <= 23; e++) begin
      step(e == 10 || e == 15, 1'b0);
      chk_out("chain", e, rng(e, 10, 12) | rng(e, 15, 17), rng(e, 10, 19), 0, 0);
    end

    // 6a: clear with pending=2 and a simultaneous pulse
    reset_dut();
    for (int e = 1; e <= 17; e++) begin
      step(rng(e, 10, 13) == 1, e == 13);
      if (e == 11)      p_exp = 1;
      else if (e == 12) p_exp = 2;
      else              p_exp = 0;
      chk_out("clear", e, rng(e, 10, 12), rng(e, 10, 12), p_exp, 0);
    end

    // 6b: asynchronous reset in the middle of GAP with a queued event
    reset_dut();
    for (int e = 1; e <= 14; e++) begin
      step(e == 10 || e == 11, 1'b0);
    end
    chk_out("pre_async", 14, 0, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 14, 0, 0, 0, 0);
    #2;
    rst_n    = 1'b1;
    pulse_in = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_rst", 1, 1, 1, 0, 0);
    step(1'b0, 1'b0);
    chk_out("post_rst", 2, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
